// File: rtl/fetch_pkg.sv
`default_nettype none
// =============================================================================
// Module      : fetch_pkg
// Description : Thread-count constants and thread-id type shared by the fetch
//               front end (scheduler, fetch unit, branch logic).
// Revision    : 1.0 - initial release
// =============================================================================
package fetch_pkg;

    localparam int NUM_THREADS     = 4;
    localparam int THREAD_ID_WIDTH = 2;

    typedef logic [THREAD_ID_WIDTH-1:0] thread_id_t;

endpackage
`default_nettype wire

// File: rtl/rr_priority_picker.sv
`default_nettype none
// =============================================================================
// Module      : rr_priority_picker
// Description : Combinational round-robin picker; first requester strictly
//               after the pointer wins, the pointer itself is checked last.
// Revision    : 1.0 - initial release
// =============================================================================
module rr_priority_picker
    import fetch_pkg::*;
(
    input  logic [NUM_THREADS-1:0] i_req,
    input  thread_id_t             i_ptr,
    output thread_id_t             o_winner,
    output logic                   o_any_valid
);

    logic [NUM_THREADS-1:0] w_rot;
    thread_id_t             w_offset;

    // Bit i of w_rot is thread (ptr+1+i); thread-id arithmetic wraps modulo NUM_THREADS.
    always_comb begin
        w_rot    = '0;
        w_offset = '0;
        for (int i = 0; i < NUM_THREADS; i++) begin
            w_rot[i] = i_req[i_ptr + thread_id_t'(1) + thread_id_t'(i)];
        end
        for (int i = NUM_THREADS - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_offset = thread_id_t'(i);
            end
        end
    end

    assign o_winner    = i_ptr + thread_id_t'(1) + w_offset;
    assign o_any_valid = |i_req;

endmodule
`default_nettype wire

// File: rtl/fetch_thread_scheduler.sv
`default_nettype none
// =============================================================================
// Module      : fetch_thread_scheduler
// Description : Picks the hardware thread the fetch unit advances each cycle;
//               round-robin over enabled threads not blocked by an I-cache miss.
// Revision    : 1.0 - initial release
// =============================================================================
module fetch_thread_scheduler
    import fetch_pkg::*;
#(
    parameter int MISS_PENALTY = 8,
    parameter int CNT_WIDTH    = 4
) (
    input  logic                   i_Clk,
    input  logic                   i_Reset,
    input  logic                   i_Stall,
    input  logic [NUM_THREADS-1:0] i_thread_enable,
    input  logic                   i_icache_miss,
    input  thread_id_t             i_icache_miss_thread,
    input  logic                   i_refill_done,
    input  thread_id_t             i_refill_thread,
    output thread_id_t             o_thread_choice,
    output logic                   o_thread_valid,
    output logic [NUM_THREADS-1:0] o_thread_blocked
);

    localparam logic [CNT_WIDTH-1:0] c_PENALTY = CNT_WIDTH'(MISS_PENALTY);

    logic [CNT_WIDTH-1:0]   r_cnt [NUM_THREADS];
    logic [NUM_THREADS-1:0] w_elig;
    thread_id_t             r_ptr;
    thread_id_t             r_choice;
    logic                   r_valid;
    thread_id_t             w_winner;
    logic                   w_any;

    genvar t;
    generate
        for (t = 0; t < NUM_THREADS; t++) begin : g_thread
            logic w_miss_hit;
            logic w_refill_hit;

            assign w_miss_hit   = i_icache_miss && (i_icache_miss_thread == thread_id_t'(t));
            assign w_refill_hit = i_refill_done && (i_refill_thread == thread_id_t'(t));

            // Counters run through stalls; a miss outranks a refill for the same thread.
            always_ff @(posedge i_Clk or posedge i_Reset) begin
                if (i_Reset) begin
                    r_cnt[t] <= '0;
                end else if (w_miss_hit) begin
                    r_cnt[t] <= c_PENALTY;
                end else if (w_refill_hit) begin
                    r_cnt[t] <= '0;
                end else if (r_cnt[t] != '0) begin
                    r_cnt[t] <= r_cnt[t] - 1'b1;
                end
            end

            assign o_thread_blocked[t] = (r_cnt[t] != '0);
            assign w_elig[t] = i_thread_enable[t] && !o_thread_blocked[t] && !w_miss_hit;
        end
    endgenerate

    rr_priority_picker u_picker (
        .i_req       (w_elig),
        .i_ptr       (r_ptr),
        .o_winner    (w_winner),
        .o_any_valid (w_any)
    );

    // Pointer resets to the last thread so the first grant lands on thread 0.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            r_ptr    <= thread_id_t'(NUM_THREADS - 1);
            r_choice <= '0;
            r_valid  <= 1'b0;
        end else if (!i_Stall) begin
            r_valid <= w_any;
            if (w_any) begin
                r_choice <= w_winner;
                r_ptr    <= w_winner;
            end
        end
    end

    assign o_thread_choice = r_choice;
    assign o_thread_valid  = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_fetch_thread_scheduler.sv
`default_nettype none
// =============================================================================
// Module      : tb_fetch_thread_scheduler
// Description : Self-checking bench: directed vector table, multi-cycle corner
//               sequences, and randomized traffic against a reference model.
// Revision    : 1.0 - initial release
// =============================================================================
module tb_fetch_thread_scheduler;
    import fetch_pkg::*;

    localparam int PEN = 8;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   stall;
    logic [NUM_THREADS-1:0] en;
    logic                   miss;
    thread_id_t             miss_tid;
    logic                   refill;
    thread_id_t             refill_tid;
    thread_id_t             choice;
    logic                   valid;
    logic [NUM_THREADS-1:0] blocked;

    int n_cmp = 0;
    int n_err = 0;

    fetch_thread_scheduler #(.MISS_PENALTY(PEN), .CNT_WIDTH(4)) dut (
        .i_Clk                (clk),
        .i_Reset              (rst),
        .i_Stall              (stall),
        .i_thread_enable      (en),
        .i_icache_miss        (miss),
        .i_icache_miss_thread (miss_tid),
        .i_refill_done        (refill),
        .i_refill_thread      (refill_tid),
        .o_thread_choice      (choice),
        .o_thread_valid       (valid),
        .o_thread_blocked     (blocked)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       stall;
        logic [3:0] en;
        logic       miss;
        int         mtid;
        logic       refill;
        int         rtid;
        int         exp_choice;
        logic       exp_valid;
        logic [3:0] exp_blocked;
    } vec_t;

    vec_t vecs [17];

    // Reference model state
    int m_cnt [NUM_THREADS];
    int m_ptr;
    int m_choice;
    int m_valid;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic s, input logic [3:0] e, input logic m, input int mt,
                         input logic r, input int rt);
        stall      = s;
        en         = e;
        miss       = m;
        miss_tid   = thread_id_t'(mt);
        refill     = r;
        refill_tid = thread_id_t'(rt);
    endtask

    task automatic do_reset();
        drive(1'b0, 4'b0000, 1'b0, 0, 1'b0, 0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int t = 0; t < NUM_THREADS; t++) m_cnt[t] = 0;
        m_ptr    = NUM_THREADS - 1;
        m_choice = 0;
        m_valid  = 0;
    endtask

    // Advance the model by one clock edge using the current inputs.
    task automatic model_step();
        int winner;
        bit found;
        found  = 0;
        winner = 0;
        for (int k = 1; k <= NUM_THREADS && !found; k++) begin
            int cand;
            cand = (m_ptr + k) % NUM_THREADS;
            if (en[cand] && m_cnt[cand] == 0 && !(miss && int'(miss_tid) == cand)) begin
                found  = 1;
                winner = cand;
            end
        end
        if (!stall) begin
            if (found) begin
                m_choice = winner;
                m_valid  = 1;
                m_ptr    = winner;
            end else begin
                m_valid = 0;
            end
        end
        for (int t = 0; t < NUM_THREADS; t++) begin
            if (miss && int'(miss_tid) == t)          m_cnt[t] = PEN;
            else if (refill && int'(refill_tid) == t) m_cnt[t] = 0;
            else if (m_cnt[t] > 0)                    m_cnt[t] = m_cnt[t] - 1;
        end
    endtask

    function automatic int model_blocked();
        int b;
        b = 0;
        for (int t = 0; t < NUM_THREADS; t++) if (m_cnt[t] != 0) b |= (1 << t);
        return b;
    endfunction

    initial begin
        rst = 1'b1;
        drive(1'b0, 4'b0000, 1'b0, 0, 1'b0, 0);

        //           stall en      miss mt refill rt  choice valid blocked
        vecs[0]  = '{1'b0, 4'b1111, 1'b0, 0, 1'b0, 0, 0, 1'b1, 4'b0000};
        vecs[1]  = '{1'b0, 4'b1111, 1'b0, 0, 1'b0, 0, 1, 1'b1, 4'b0000};
        vecs[2]  = '{1'b0, 4'b1111, 1'b0, 0, 1'b0, 0, 2, 1'b1, 4'b0000};
        vecs[3]  = '{1'b0, 4'b1111, 1'b0, 0, 1'b0, 0, 3, 1'b1, 4'b0000};
        vecs[4]  = '{1'b0, 4'b1111, 1'b0, 0, 1'b0, 0, 0, 1'b1, 4'b0000};
        vecs[5]  = '{1'b0, 4'b0101, 1'b0, 0, 1'b0, 0, 2, 1'b1, 4'b0000};
        vecs[6]  = '{1'b0, 4'b0101, 1'b0, 0, 1'b0, 0, 0, 1'b1, 4'b0000};
        vecs[7]  = '{1'b0, 4'b0101, 1'b0, 0, 1'b0, 0, 2, 1'b1, 4'b0000};
        vecs[8]  = '{1'b0, 4'b1111, 1'b1, 1, 1'b0, 0, 3, 1'b1, 4'b0010};
        vecs[9]  = '{1'b0, 4'b1111, 1'b0, 0, 1'b0, 0, 0, 1'b1, 4'b0010};
        vecs[10] = '{1'b1, 4'b1111, 1'b0, 0, 1'b0, 0, 0, 1'b1, 4'b0010};
        vecs[11] = '{1'b0, 4'b0000, 1'b0, 0, 1'b0, 0, 0, 1'b0, 4'b0010};
        vecs[12] = '{1'b0, 4'b0010, 1'b0, 0, 1'b0, 0, 0, 1'b0, 4'b0010};
        vecs[13] = '{1'b0, 4'b0010, 1'b0, 0, 1'b1, 1, 0, 1'b0, 4'b0000};
        vecs[14] = '{1'b0, 4'b0010, 1'b0, 0, 1'b0, 0, 1, 1'b1, 4'b0000};
        vecs[15] = '{1'b0, 4'b0010, 1'b0, 0, 1'b0, 0, 1, 1'b1, 4'b0000};
        vecs[16] = '{1'b0, 4'b0100, 1'b1, 2, 1'b1, 2, 1, 1'b0, 4'b0100};

        do_reset();
        check("reset_choice", int'(choice), 0);
        check("reset_valid", int'(valid), 0);
        check("reset_blocked", int'(blocked), 0);

        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].stall, vecs[i].en, vecs[i].miss, vecs[i].mtid,
                  vecs[i].refill, vecs[i].rtid);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_choice", i), int'(choice), vecs[i].exp_choice);
            check($sformatf("vec%0d_valid", i), int'(valid), int'(vecs[i].exp_valid));
            check($sformatf("vec%0d_blocked", i), int'(blocked), int'(vecs[i].exp_blocked));
        end

        // Miss on the only enabled thread: blocked for the full penalty, then granted.
        do_reset();
        drive(1'b0, 4'b0010, 1'b1, 1, 1'b0, 0);
        @(posedge clk);
        #1;
        check("pen_load_blocked", int'(blocked), 2);
        check("pen_load_valid", int'(valid), 0);
        drive(1'b0, 4'b0010, 1'b0, 0, 1'b0, 0);
        for (int k = 1; k <= PEN; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("pen_wait%0d_valid", k), int'(valid), 0);
            check($sformatf("pen_wait%0d_blocked", k), int'(blocked[1]), (k < PEN) ? 1 : 0);
        end
        @(posedge clk);
        #1;
        check("pen_regrant_valid", int'(valid), 1);
        check("pen_regrant_choice", int'(choice), 1);

        // Asynchronous reset mid-block clears everything without a clock edge.
        drive(1'b0, 4'b1111, 1'b1, 2, 1'b0, 0);
        @(posedge clk);
        #1;
        check("pre_rst_blocked", int'(blocked), 4);
        drive(1'b0, 4'b1111, 1'b0, 0, 1'b0, 0);
        #2 rst = 1'b1;
        #1;
        check("async_rst_choice", int'(choice), 0);
        check("async_rst_valid", int'(valid), 0);
        check("async_rst_blocked", int'(blocked), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_choice", int'(choice), 0);
        check("post_rst_valid", int'(valid), 1);

        // Randomized traffic against the reference model.
        do_reset();
        for (int c = 0; c < 400; c++) begin
            drive(($urandom_range(0, 7) == 0), 4'($urandom_range(0, 15)),
                  ($urandom_range(0, 3) == 0), int'($urandom_range(0, 3)),
                  ($urandom_range(0, 3) == 0), int'($urandom_range(0, 3)));
            model_step();
            @(posedge clk);
            #1;
            check($sformatf("rnd%0d_choice", c), int'(choice), m_choice);
            check($sformatf("rnd%0d_valid", c), int'(valid), m_valid);
            check($sformatf("rnd%0d_blocked", c), int'(blocked), model_blocked());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
